// File: rtl/apb_pkg.sv
// apb_pkg: shared APB master types, response codes and default timeout
package apb_pkg;
  typedef enum logic [1:0] {
    APB_IDLE   = 2'd0,
    APB_SETUP  = 2'd1,
    APB_ACCESS = 2'd2
  } apb_state_e;
  localparam logic [1:0] APB_RESP_OKAY   = 2'b00;
  localparam logic [1:0] APB_RESP_SLVERR = 2'b10;
  localparam int APB_TIMEOUT_CYCLES = 256;
endpackage

// File: rtl/apb_timeout_cnt.sv
// apb_timeout_cnt: counts ACCESS cycles without pready; expired on the last allowed cycle
module apb_timeout_cnt
  import apb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES
) (
  input  logic apb_clk,
  input  logic sys_aresetn,
  input  logic enable,
  input  logic clear,
  output logic expired
);
  localparam int W = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [W-1:0] cnt;
  assign expired = enable && cnt == W'(TIMEOUT_CYCLES - 1);
  // count while enabled, restart on clear, saturate once expired
  always_ff @(posedge apb_clk or negedge sys_aresetn)
    if (!sys_aresetn) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (enable && !expired) cnt <= cnt + 1'b1;
endmodule

// File: rtl/apb_master_fsm.sv
// apb_master_fsm: one APB transfer per start pulse; optional ACCESS timeout via APB_MASTER_TIMEOUT_EN
module apb_master_fsm
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES
) (
  input  logic                    apb_clk,
  input  logic                    sys_aresetn,
  input  logic                    start_read,
  input  logic                    start_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb,
  input  logic [2:0]              req_prot,
  output logic                    read_data_valid,
  output logic                    done_write,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              resp,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [2:0]              pprot,
  output logic                    pwrite,
  output logic                    psel,
  output logic                    penable,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pready,
  input  logic                    pslverr
);
  apb_state_e state;
  logic pend_rd, pend_wr, eff_rd, eff_wr, done, launch, timeout;
  // psel/penable decode straight from state so an async reset drops them at once
  assign psel    = state != APB_IDLE;
  assign penable = state == APB_ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
  apb_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .apb_clk     (apb_clk),
    .sys_aresetn (sys_aresetn),
    .enable      (state == APB_ACCESS && !pready),
    .clear       (state == APB_SETUP),
    .expired     (timeout)
  );
`else
  assign timeout = 1'b0;
`endif
  // a start arriving this cycle is treated like an already-pending one; read wins
  always_comb begin
    eff_rd = pend_rd | start_read;
    eff_wr = pend_wr | start_write;
    done   = state == APB_ACCESS && (pready || timeout);
    launch = (state == APB_IDLE || done) && (eff_rd || eff_wr);
  end
  // state and one-deep pending flags per direction
  always_ff @(posedge apb_clk or negedge sys_aresetn)
    if (!sys_aresetn) begin
      state   <= APB_IDLE;
      pend_rd <= 1'b0;
      pend_wr <= 1'b0;
    end else begin
      pend_rd <= eff_rd && !launch;
      pend_wr <= eff_wr && !(launch && !eff_rd);
      state   <= launch ? APB_SETUP : state == APB_SETUP ? APB_ACCESS : done ? APB_IDLE : state;
    end
  // request attributes captured at launch and held through ACCESS
  always_ff @(posedge apb_clk or negedge sys_aresetn)
    if (!sys_aresetn) begin
      paddr  <= '0;
      pwdata <= '0;
      pstrb  <= '0;
      pprot  <= '0;
      pwrite <= 1'b0;
    end else if (launch) begin
      paddr  <= req_addr;
      pwdata <= req_wdata;
      pstrb  <= req_wstrb;
      pprot  <= req_prot;
      pwrite <= !eff_rd;
    end
  // completion pulses and response/read data capture; a timeout reports SLVERR with zero data
  always_ff @(posedge apb_clk or negedge sys_aresetn)
    if (!sys_aresetn) begin
      read_data_valid <= 1'b0;
      done_write      <= 1'b0;
      rdata           <= '0;
      resp            <= APB_RESP_OKAY;
    end else begin
      read_data_valid <= done && !pwrite;
      done_write      <= done && pwrite;
      if (done) resp <= (!pready || pslverr) ? APB_RESP_SLVERR : APB_RESP_OKAY;
      if (done && !pwrite) rdata <= pready ? prdata : '0;
    end
endmodule

// File: tb/tb_apb_master_fsm.sv
// tb_apb_master_fsm: directed checks of APB master sequencing, pending starts, timeout and reset
module tb_apb_master_fsm;
  logic        apb_clk = 1'b0;
  logic        sys_aresetn = 1'b0;
  logic        start_read = 1'b0, start_write = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic [2:0]  req_prot = '0;
  logic        read_data_valid, done_write;
  logic [31:0] rdata, paddr, pwdata;
  logic [1:0]  resp;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic        pwrite, psel, penable;
  logic [31:0] prdata = '0;
  logic        pready = 1'b0, pslverr = 1'b0;
  int n_tests = 0, n_fail = 0;

  apb_master_fsm #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .apb_clk(apb_clk), .sys_aresetn(sys_aresetn),
    .start_read(start_read), .start_write(start_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_prot(req_prot),
    .read_data_valid(read_data_valid), .done_write(done_write), .rdata(rdata), .resp(resp),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot), .pwrite(pwrite),
    .psel(psel), .penable(penable), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 apb_clk = ~apb_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge apb_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    cyc(); cyc();
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_rdv", read_data_valid, 0);
    chk("rst_dw", done_write, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_resp", resp, 0);
    sys_aresetn = 1'b1;
    cyc();
    // zero-wait read
    req_addr = 32'h40; req_prot = 3'b010; prdata = 32'hDEADBEEF; pready = 1'b1;
    start_read = 1'b1; cyc(); start_read = 1'b0;
    chk("rd_setup_psel", psel, 1);
    chk("rd_setup_penable", penable, 0);
    chk("rd_paddr", paddr, 32'h40);
    chk("rd_pwrite", pwrite, 0);
    chk("rd_pprot", pprot, 3'b010);
    cyc();
    chk("rd_access_penable", penable, 1);
    chk("rd_access_rdv", read_data_valid, 0);
    cyc();
    chk("rd_rdv", read_data_valid, 1);
    chk("rd_rdata", rdata, 32'hDEADBEEF);
    chk("rd_resp", resp, 2'b00);
    chk("rd_psel_drop", psel, 0);
    cyc();
    chk("rd_rdv_width", read_data_valid, 0);
    // write with 4 wait states and SLVERR
    pready = 1'b0; pslverr = 1'b1; req_addr = 32'h80; req_wdata = 32'h12345678; req_wstrb = 4'hF;
    start_write = 1'b1; cyc(); start_write = 1'b0;
    req_wdata = 32'h0;
    chk("wr_setup_pwrite", pwrite, 1);
    chk("wr_setup_pwdata", pwdata, 32'h12345678);
    chk("wr_pstrb", pstrb, 4'hF);
    cyc();
    for (int i = 0; i < 4; i++) begin
      chk("wr_wait_penable", penable, 1);
      chk("wr_wait_pwdata", pwdata, 32'h12345678);
      chk("wr_wait_dw", done_write, 0);
      cyc();
    end
    pready = 1'b1;
    chk("wr_ready_pwdata", pwdata, 32'h12345678);
    cyc();
    pready = 1'b0; pslverr = 1'b0;
    chk("wr_dw", done_write, 1);
    chk("wr_rdv", read_data_valid, 0);
    chk("wr_resp", resp, 2'b10);
    chk("wr_rdata_kept", rdata, 32'hDEADBEEF);
    cyc();
    chk("wr_dw_width", done_write, 0);
    // simultaneous starts: read first, write SETUP right after read completion
    pready = 1'b1; prdata = 32'hA5A50001; req_addr = 32'hC0; req_wdata = 32'h55AA55AA;
    start_read = 1'b1; start_write = 1'b1; cyc(); start_read = 1'b0; start_write = 1'b0;
    chk("both_first_pwrite", pwrite, 0);
    cyc();
    chk("both_access", penable, 1);
    cyc();
    chk("both_rdv", read_data_valid, 1);
    chk("both_dw_not_yet", done_write, 0);
    chk("both_wr_setup_psel", psel, 1);
    chk("both_wr_setup_penable", penable, 0);
    chk("both_wr_pwrite", pwrite, 1);
    chk("both_rdata", rdata, 32'hA5A50001);
    cyc();
    chk("both_rdv_off", read_data_valid, 0);
    chk("both_wr_access", penable, 1);
    cyc();
    chk("both_dw", done_write, 1);
    chk("both_rdv_excl", read_data_valid, 0);
    chk("both_idle", psel, 0);
    cyc();
    // start arriving during ACCESS becomes pending, launched with no idle cycle
    pready = 1'b0;
    start_write = 1'b1; cyc(); start_write = 1'b0;
    cyc();
    start_read = 1'b1; cyc(); start_read = 1'b0;
    chk("pend_still_access", penable, 1);
    pready = 1'b1; prdata = 32'h0BADF00D;
    cyc();
    chk("pend_dw", done_write, 1);
    chk("pend_no_idle_psel", psel, 1);
    chk("pend_setup_penable", penable, 0);
    chk("pend_rd_pwrite", pwrite, 0);
    cyc();
    chk("pend_rd_access", penable, 1);
    cyc();
    chk("pend_rdv", read_data_valid, 1);
    chk("pend_rdata", rdata, 32'h0BADF00D);
    cyc();
    // pready held low
    pready = 1'b0; prdata = 32'h11112222;
    start_read = 1'b1; cyc(); start_read = 1'b0;
    cyc();
`ifdef APB_MASTER_TIMEOUT_EN
    repeat (7) cyc();
    chk("to_last_access", penable, 1);
    chk("to_no_rdv_yet", read_data_valid, 0);
    cyc();
    chk("to_rdv", read_data_valid, 1);
    chk("to_resp", resp, 2'b10);
    chk("to_rdata", rdata, 0);
    chk("to_idle", psel, 0);
`else
    repeat (1000) cyc();
    chk("nto_psel", psel, 1);
    chk("nto_penable", penable, 1);
    chk("nto_rdv", read_data_valid, 0);
    pready = 1'b1;
    cyc();
    chk("nto_rdv_late", read_data_valid, 1);
    chk("nto_rdata", rdata, 32'h11112222);
    chk("nto_resp", resp, 2'b00);
`endif
    cyc();
    // reset in the middle of ACCESS
    pready = 1'b0;
    start_write = 1'b1; cyc(); start_write = 1'b0;
    cyc();
    chk("rstm_access", penable, 1);
    #2;
    pready = 1'b1;
    sys_aresetn = 1'b0;
    #1;
    chk("rstm_psel_async", psel, 0);
    chk("rstm_penable_async", penable, 0);
    cyc();
    chk("rstm_no_dw", done_write, 0);
    chk("rstm_rdata", rdata, 0);
    chk("rstm_resp", resp, 0);
    sys_aresetn = 1'b1;
    cyc();
    chk("rstm_no_dw_after", done_write, 0);
    prdata = 32'hCAFE0000; req_addr = 32'h44;
    start_read = 1'b1; cyc(); start_read = 1'b0;
    chk("post_setup", psel, 1);
    cyc();
    cyc();
    chk("post_rdv", read_data_valid, 1);
    chk("post_rdata", rdata, 32'hCAFE0000);
    cyc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
